ahb_qos_arbiter: RTL and testbench

- Priority/QoS AHB bus arbiter for up to 4 masters on the shared AHB address/data bus.
- Features: per-master 2-bit priority, age-based starvation promotion, fixed-burst protection, a cap on undefined-length INCR bursts, and HLOCK locked sequences.
- Produces address-phase owner HMASTER and data-phase owner HMASTER_D. The master/slave multiplexers use these to steer the bus.

---
 rtl/ahb_qos_arbiter.sv | 218 +++++++++++++++++++++
 tb/tb_ahb_qos_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_qos_arbiter.sv
// -----------------------------------------------------------------------------
// ahb_qos_arbiter
//   Priority/QoS arbiter for up to four AHB masters sharing one address/data
//   bus. Each requester competes on a tier: its static 2-bit priority, or the
//   urgent tier 4 once it has waited AGE_LIMIT cycles. Ties rotate round-robin
//   from the master after the current address-phase owner. Fixed-length
//   bursts and locked sequences keep the grant. Undefined-length INCR bursts
//   keep it until MAX_INCR beats while another master is waiting.
//
// Ports
//   HCLK        bus clock
//   HRESETn     asynchronous active-low reset
//   HBUSREQ     per-master bus request
//   HLOCK       per-master locked-sequence request
//   PRIO        static priority, PRIO[2i+1:2i] for master i (3 = highest)
//   HREADY      global transfer-complete
//   HTRANS      owner's transfer type (IDLE/BUSY/NONSEQ/SEQ)
//   HBURST      owner's burst type
//   HGRANT      registered one-hot grant
//   HMASTER     address-phase owner
//   HMASTER_D   data-phase owner
//   HMASTLOCK   current address phase belongs to a locked sequence
// -----------------------------------------------------------------------------
module ahb_qos_arbiter #(
    parameter int unsigned NUM_MASTERS = 4,
    parameter int unsigned MAX_INCR    = 16,
    parameter int unsigned AGE_LIMIT   = 32
) (
    input  logic                       HCLK,
    input  logic                       HRESETn,
    input  logic [NUM_MASTERS-1:0]     HBUSREQ,
    input  logic [NUM_MASTERS-1:0]     HLOCK,
    input  logic [2*NUM_MASTERS-1:0]   PRIO,
    input  logic                       HREADY,
    input  logic [1:0]                 HTRANS,
    input  logic [2:0]                 HBURST,
    output logic [NUM_MASTERS-1:0]     HGRANT,
    output logic [1:0]                 HMASTER,
    output logic [1:0]                 HMASTER_D,
    output logic                       HMASTLOCK
);

    // Counter must hold both MAX_INCR and the longest fixed-burst remainder (15).
    localparam int unsigned CNT_MAX = (MAX_INCR > 15) ? MAX_INCR : 15;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned AGE_W   = $clog2(AGE_LIMIT + 1);

    typedef enum logic [1:0] {
        ST_ARB,
        ST_BURST,
        ST_INCR,
        ST_LOCKED
    } state_t;

    state_t             state;
    logic [1:0]         gi;
    logic [CNT_W-1:0]   cnt;
    logic [AGE_W-1:0]   age [NUM_MASTERS];

    logic [2:0]         tier [NUM_MASTERS];
    logic [2:0]         best;
    logic [1:0]         win;
    logic [1:0]         idx;
    logic               found;

    logic               is_seq;
    logic               is_nonseq;
    logic               is_idle;
    logic               lock_next;
    logic               start_burst;
    logic               others_req;
    logic [CNT_W-1:0]   len_m1;

    function automatic logic [NUM_MASTERS-1:0] onehot(input logic [1:0] sel);
        onehot      = '0;
        onehot[sel] = 1'b1;
    endfunction

    assign is_seq    = HREADY && (HTRANS == 2'b11);
    assign is_nonseq = HREADY && (HTRANS == 2'b10);
    assign is_idle   = HREADY && (HTRANS == 2'b00);
    assign lock_next = HLOCK[gi] & HBUSREQ[gi];

    // A burst is only tracked when the grant is still with the master driving
    // the NONSEQ; if the grant has already moved on, that master is handing
    // the bus over on this edge and its burst is not protected.
    assign start_burst = is_nonseq && (gi == HMASTER);

    assign others_req = |(HBUSREQ & ~onehot(HMASTER));

    // Beats remaining after the NONSEQ of a fixed-length burst.
    always_comb begin
        len_m1 = '0;
        unique case (HBURST)
            3'b010, 3'b011: len_m1 = CNT_W'(3);
            3'b100, 3'b101: len_m1 = CNT_W'(7);
            3'b110, 3'b111: len_m1 = CNT_W'(15);
            default:        len_m1 = '0;
        endcase
    end

    // Tier per master: urgent (4) once aged out, else static priority.
    always_comb begin
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (age[i] >= AGE_W'(AGE_LIMIT)) begin
                tier[i] = 3'd4;
            end else begin
                tier[i] = {1'b0, PRIO[2*i +: 2]};
            end
        end
    end

    // Highest tier among requesters, then the first such master scanning
    // from HMASTER+1 round the ring. No requester parks on the current grant.
    always_comb begin
        best  = '0;
        win   = gi;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (HBUSREQ[i] && (tier[i] > best)) begin
                best = tier[i];
            end
        end
        for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
            idx = HMASTER + 2'(k);
            if (!found && HBUSREQ[idx] && (tier[idx] == best)) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= ST_ARB;
            gi        <= '0;
            HGRANT    <= NUM_MASTERS'(1);
            HMASTER   <= '0;
            HMASTER_D <= '0;
            HMASTLOCK <= 1'b0;
            cnt       <= '0;
        end else begin
            if (HREADY) begin
                HMASTER   <= gi;
                HMASTER_D <= HMASTER;
                HMASTLOCK <= lock_next;
            end

            unique case (state)
                ST_ARB: begin
                    if (HREADY && lock_next) begin
                        // Grant stays with the master entering the lock.
                        state <= ST_LOCKED;
                    end else if (start_burst && (HBURST == 3'b001)) begin
                        state <= ST_INCR;
                        cnt   <= CNT_W'(1);
                    end else if (start_burst && (HBURST != 3'b000)) begin
                        state <= ST_BURST;
                        cnt   <= len_m1;
                    end else begin
                        gi     <= win;
                        HGRANT <= onehot(win);
                    end
                end

                ST_BURST: begin
                    if (is_seq) begin
                        if (cnt == CNT_W'(1)) begin
                            state <= ST_ARB;
                        end
                        cnt <= cnt - 1'b1;
                    end else if (is_idle || is_nonseq) begin
                        state <= ST_ARB;
                    end
                end

                ST_INCR: begin
                    if (HREADY) begin
                        if (!HBUSREQ[HMASTER] || (HTRANS == 2'b00) ||
                            ((cnt == CNT_W'(MAX_INCR)) && others_req)) begin
                            state <= ST_ARB;
                        end else if ((HTRANS == 2'b11) && (cnt != CNT_W'(MAX_INCR))) begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end

                ST_LOCKED: begin
                    if (HREADY && !HLOCK[HMASTER]) begin
                        state <= ST_ARB;
                    end
                end

                default: state <= ST_ARB;
            endcase
        end
    end

    // Waiting-time counters; held at zero while the master owns the address
    // phase or is not requesting, and cleared on the edge it takes the bus.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
                age[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
                if (!HBUSREQ[i] || (HMASTER == 2'(i)) || (HREADY && (gi == 2'(i)))) begin
                    age[i] <= '0;
                end else if (age[i] != AGE_W'(AGE_LIMIT)) begin
                    age[i] <= age[i] + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb_qos_arbiter.sv
`timescale 1ns/1ps
module tb_ahb_qos_arbiter;

    logic       HCLK = 1'b0;
    logic       HRESETn;
    logic [3:0] HBUSREQ;
    logic [3:0] HLOCK;
    logic [7:0] PRIO;
    logic       HREADY;
    logic [1:0] HTRANS;
    logic [2:0] HBURST;
    logic [3:0] HGRANT;
    logic [1:0] HMASTER;
    logic [1:0] HMASTER_D;
    logic       HMASTLOCK;

    int tests = 0;
    int fails = 0;

    always #5 HCLK = ~HCLK;

    ahb_qos_arbiter #(
        .NUM_MASTERS (4),
        .MAX_INCR    (16),
        .AGE_LIMIT   (32)
    ) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HBUSREQ   (HBUSREQ),
        .HLOCK     (HLOCK),
        .PRIO      (PRIO),
        .HREADY    (HREADY),
        .HTRANS    (HTRANS),
        .HBURST    (HBURST),
        .HGRANT    (HGRANT),
        .HMASTER   (HMASTER),
        .HMASTER_D (HMASTER_D),
        .HMASTLOCK (HMASTLOCK)
    );

    typedef struct {
        logic [3:0] req;
        logic [3:0] lock;
        logic [7:0] prio;
        logic       ready;
        logic [3:0] grant;
        logic [1:0] hm;
        logic [1:0] hmd;
        logic       ml;
    } vec_t;

    vec_t vecs [17];

    localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic do_reset();
        HRESETn = 1'b0;
        HBUSREQ = 4'b0000;
        HLOCK   = 4'b0000;
        PRIO    = 8'h00;
        HREADY  = 1'b1;
        HTRANS  = T_IDLE;
        HBURST  = 3'b000;
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        HRESETn = 1'b1;
    endtask

    task automatic check_outs(input string tag, input logic [3:0] g, input logic [1:0] hm,
                              input logic [1:0] hmd, input logic ml);
        check({tag, "_grant"}, 32'(HGRANT), 32'(g));
        check({tag, "_hmaster"}, 32'(HMASTER), 32'(hm));
        check({tag, "_hmaster_d"}, 32'(HMASTER_D), 32'(hmd));
        check({tag, "_mastlock"}, 32'(HMASTLOCK), 32'(ml));
    endtask

    initial begin
        int found_at;
        logic [3:0] rr_exp [8];

        //            req      lock     prio   rdy   grant    hm  hmd ml
        vecs[0]  = '{4'b0000, 4'b0000, 8'h55, 1'b1, 4'b0001, 2'd0, 2'd0, 1'b0};
        vecs[1]  = '{4'b1111, 4'b0000, 8'h5D, 1'b1, 4'b0010, 2'd0, 2'd0, 1'b0};
        vecs[2]  = '{4'b1111, 4'b0000, 8'h5D, 1'b1, 4'b0010, 2'd1, 2'd0, 1'b0};
        vecs[3]  = '{4'b1111, 4'b0000, 8'h5D, 1'b1, 4'b0010, 2'd1, 2'd1, 1'b0};
        vecs[4]  = '{4'b1111, 4'b0000, 8'h55, 1'b1, 4'b0100, 2'd1, 2'd1, 1'b0};
        vecs[5]  = '{4'b1111, 4'b0000, 8'h55, 1'b0, 4'b0100, 2'd1, 2'd1, 1'b0};
        vecs[6]  = '{4'b1111, 4'b0000, 8'h55, 1'b1, 4'b0100, 2'd2, 2'd1, 1'b0};
        vecs[7]  = '{4'b1111, 4'b0000, 8'h55, 1'b1, 4'b1000, 2'd2, 2'd2, 1'b0};
        vecs[8]  = '{4'b0101, 4'b0000, 8'h55, 1'b1, 4'b0001, 2'd3, 2'd2, 1'b0};
        vecs[9]  = '{4'b0000, 4'b0000, 8'h55, 1'b1, 4'b0001, 2'd0, 2'd3, 1'b0};
        vecs[10] = '{4'b1000, 4'b0000, 8'h15, 1'b1, 4'b1000, 2'd0, 2'd0, 1'b0};
        vecs[11] = '{4'b1010, 4'b0000, 8'h15, 1'b1, 4'b0010, 2'd3, 2'd0, 1'b0};
        vecs[12] = '{4'b0010, 4'b0010, 8'h15, 1'b1, 4'b0010, 2'd1, 2'd3, 1'b1};
        vecs[13] = '{4'b1111, 4'b0010, 8'hFF, 1'b1, 4'b0010, 2'd1, 2'd1, 1'b1};
        vecs[14] = '{4'b1111, 4'b0000, 8'hFF, 1'b0, 4'b0010, 2'd1, 2'd1, 1'b1};
        vecs[15] = '{4'b1111, 4'b0000, 8'hFF, 1'b1, 4'b0010, 2'd1, 2'd1, 1'b0};
        vecs[16] = '{4'b1111, 4'b0000, 8'h55, 1'b1, 4'b0100, 2'd1, 2'd1, 1'b0};

        // Reset and park
        do_reset();
        check_outs("reset", 4'b0001, 2'd0, 2'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            check_outs($sformatf("park%0d", i), 4'b0001, 2'd0, 2'd0, 1'b0);
        end

        // Table: priority, round-robin, wait states, lock entry/exit
        for (int i = 0; i < 17; i++) begin
            HBUSREQ = vecs[i].req;
            HLOCK   = vecs[i].lock;
            PRIO    = vecs[i].prio;
            HREADY  = vecs[i].ready;
            HTRANS  = T_IDLE;
            step();
            check_outs($sformatf("vec%0d", i), vecs[i].grant, vecs[i].hm, vecs[i].hmd, vecs[i].ml);
        end

        // Round-robin rotation across SINGLE transfers
        do_reset();
        rr_exp = '{4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001, 4'b0001};
        HBUSREQ = 4'b1111;
        PRIO    = 8'h55;
        HTRANS  = T_NSEQ;
        HBURST  = 3'b000;
        for (int i = 0; i < 8; i++) begin
            step();
            check($sformatf("rr%0d_grant", i), 32'(HGRANT), 32'(rr_exp[i]));
        end

        // Fixed INCR8 burst by master 2 against higher-priority master 0,
        // with wait states and a BUSY in the middle
        do_reset();
        PRIO    = 8'h13;
        HBUSREQ = 4'b0100;
        step();
        step();
        check("burst_owner", 32'(HMASTER), 32'd2);
        HBUSREQ = 4'b0101;
        HTRANS  = T_NSEQ;
        HBURST  = 3'b101;
        step();
        check("burst_nseq_grant", 32'(HGRANT), 32'b0100);
        for (int i = 0; i < 11; i++) begin
            HTRANS = (i == 6) ? T_BUSY : T_SEQ;
            HREADY = (i >= 3 && i <= 5) ? 1'b0 : 1'b1;
            step();
            check($sformatf("burst_hold%0d", i), 32'(HGRANT), 32'b0100);
        end
        HTRANS = T_IDLE;
        HREADY = 1'b1;
        step();
        check("burst_release", 32'(HGRANT), 32'b0001);

        // INCR cap: master 3 vs waiting master 0
        do_reset();
        HBUSREQ = 4'b1000;
        step();
        step();
        check("incr_owner", 32'(HMASTER), 32'd3);
        HBUSREQ = 4'b1001;
        HTRANS  = T_NSEQ;
        HBURST  = 3'b001;
        step();
        check("incr_nseq_grant", 32'(HGRANT), 32'b1000);
        HTRANS = T_SEQ;
        for (int i = 0; i < 16; i++) begin
            step();
            check($sformatf("incr_hold%0d", i), 32'(HGRANT), 32'b1000);
        end
        HTRANS = T_IDLE;
        step();
        check("incr_regrant", 32'(HGRANT), 32'b0001);
        step();
        check("incr_new_owner", 32'(HMASTER), 32'd0);

        // Starvation promotion of low-priority master 1
        do_reset();
        PRIO     = 8'h03;
        HBUSREQ  = 4'b0011;
        HTRANS   = T_NSEQ;
        HBURST   = 3'b000;
        found_at = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (found_at == 0 && HGRANT == 4'b0010) found_at = i;
        end
        check("starve_latency", 32'(found_at), 32'd33);

        // Locked sequence over three INCR4 bursts, then async reset inside it
        do_reset();
        HBUSREQ = 4'b0010;
        HLOCK   = 4'b0010;
        step();
        step();
        check("lock_grant", 32'(HGRANT), 32'b0010);
        check("lock_mastlock", 32'(HMASTLOCK), 32'd1);
        HBUSREQ = 4'b1111;
        PRIO    = 8'hFF;
        HBURST  = 3'b011;
        for (int i = 0; i < 12; i++) begin
            HTRANS = (i % 4 == 0) ? T_NSEQ : T_SEQ;
            step();
            check($sformatf("lock_hold%0d_grant", i), 32'(HGRANT), 32'b0010);
            check($sformatf("lock_hold%0d_ml", i), 32'(HMASTLOCK), 32'd1);
        end
        #3;
        HRESETn = 1'b0;
        #1;
        check_outs("async_reset", 4'b0001, 2'd0, 2'd0, 1'b0);
        @(negedge HCLK);
        HRESETn = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
